// File: rtl/mvm_tile_sequencer_if.sv
`timescale 1ns/1ps
// mvm_tile_sequencer_if: control/address bundle between the tile sequencer and its operand source / MVM.
// master: sequencer side (drives busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row)
// slave : environment side (drives start, mem_ready)
// MVM_SEQ_PERF_EN adds perf_cycles and perf_stalls to the bundle.
interface mvm_tile_sequencer_if #(
  parameter int N_ROW_TILES = 4,
  parameter int N_COL_TILES = 4
);
  localparam int WAW = (N_ROW_TILES * N_COL_TILES > 1) ? $clog2(N_ROW_TILES * N_COL_TILES) : 1;
  localparam int XAW = (N_COL_TILES > 1) ? $clog2(N_COL_TILES) : 1;
  localparam int RAW = (N_ROW_TILES > 1) ? $clog2(N_ROW_TILES) : 1;
  logic start;
  logic mem_ready;
  logic busy;
  logic done;
  logic en;
  logic ctrl;
  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
  logic out_valid;
  logic [RAW-1:0] out_row;
`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
  modport master (input start, mem_ready,
                  output busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row, perf_cycles, perf_stalls);
  modport slave  (output start, mem_ready,
                  input busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row, perf_cycles, perf_stalls);
`else
  modport master (input start, mem_ready,
                  output busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row);
  modport slave  (output start, mem_ready,
                  input busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row);
`endif
endinterface

// File: rtl/mvm_tile_sequencer.sv
`timescale 1ns/1ps
// mvm_tile_sequencer: walks the row/column tiles of one matrix-vector product for a columnwise MVM.
// clk, reset : rising-edge clock, synchronous active-high reset
// bus        : start/mem_ready in; busy, done, en, ctrl, w_addr, x_addr, out_valid, out_row out
// MVM_SEQ_PERF_EN adds perf_cycles (start..done inclusive) and perf_stalls (stalled ISSUE cycles).
module mvm_tile_sequencer #(
  parameter int EP          = 3,
  parameter int VP          = 3,
  parameter int N_ROW_TILES = 4,
  parameter int N_COL_TILES = 4,
  parameter int KLAT        = 2
) (
  input logic clk,
  input logic reset,
  mvm_tile_sequencer_if.master bus
);
  localparam int WAW = (N_ROW_TILES * N_COL_TILES > 1) ? $clog2(N_ROW_TILES * N_COL_TILES) : 1;
  localparam int XAW = (N_COL_TILES > 1) ? $clog2(N_COL_TILES) : 1;
  localparam int RAW = (N_ROW_TILES > 1) ? $clog2(N_ROW_TILES) : 1;
  if (EP < 1 || VP < 1 || N_ROW_TILES < 1 || N_COL_TILES < 1 || KLAT < 1) begin : g_cfg_check
    $error("mvm_tile_sequencer: all parameters must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [RAW-1:0] row_cnt;
  logic [XAW-1:0] col_cnt;
  logic busy_q;
  logic done_q;
  logic [KLAT-1:0] vld;
  logic [RAW-1:0] idx [KLAT];
  logic last_col;
  logic last_row;
  logic fire;
  assign last_col = col_cnt == XAW'(N_COL_TILES - 1);
  assign last_row = row_cnt == RAW'(N_ROW_TILES - 1);
  assign bus.en = state == ISSUE && bus.mem_ready;
  assign bus.ctrl = bus.en && col_cnt == '0;
  assign bus.w_addr = WAW'(row_cnt * N_COL_TILES + col_cnt);
  assign bus.x_addr = col_cnt;
  // A row tile finishes when its last column tile is issued; that event rides the delay line.
  assign fire = bus.en && last_col;
  assign bus.out_valid = vld[KLAT-1];
  assign bus.out_row = idx[KLAT-1];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vld <= '0;
      for (int i = 0; i < KLAT; i++) idx[i] <= '0;
    end else begin
      for (int i = KLAT - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        idx[i] <= idx[i-1];
      end
      vld[0] <= fire;
      idx[0] <= row_cnt;
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= ISSUE;
          busy_q <= 1'b1;
          row_cnt <= '0;
          col_cnt <= '0;
        end
        ISSUE: if (bus.mem_ready) begin
          col_cnt <= last_col ? '0 : col_cnt + 1'b1;
          if (last_col) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
          if (last_col && last_row) state <= DRAIN;
        end
        // Earlier row tiles may still drain here; only the last row's pulse ends the product.
        DRAIN: if (bus.out_valid && bus.out_row == RAW'(N_ROW_TILES - 1)) begin
          state <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MVM_SEQ_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stalls_q;
  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
  // The start cycle itself counts, so the counter loads 1 rather than 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        perf_cycles_q <= 32'd1;
        perf_stalls_q <= '0;
      end
    end else begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      if (state == ISSUE && !bus.mem_ready) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mvm_tile_sequencer.sv
`timescale 1ns/1ps
// tb_mvm_tile_sequencer: scoreboard bench for a 2x3/KLAT=2 sequencer and a 1x1/KLAT=1 sequencer.
module tb_mvm_tile_sequencer;
  typedef struct {int cyc; int ctrl; int w; int x;} iss_t;
  typedef struct {int cyc; int row;} out_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int pass_cnt = 0;
  int total = 0;
  iss_t qa_iss[$];
  iss_t qb_iss[$];
  out_t qa_out[$];
  out_t qb_out[$];
  int qa_done[$];
  int qb_done[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mvm_tile_sequencer_if #(.N_ROW_TILES(2), .N_COL_TILES(3)) a_if ();
  mvm_tile_sequencer_if #(.N_ROW_TILES(1), .N_COL_TILES(1)) b_if ();
  mvm_tile_sequencer #(.EP(3), .VP(3), .N_ROW_TILES(2), .N_COL_TILES(3), .KLAT(2)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.master));
  mvm_tile_sequencer #(.EP(3), .VP(3), .N_ROW_TILES(1), .N_COL_TILES(1), .KLAT(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.master));
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic miss(input string name, input int c);
    total++;
    $display("FAIL %s: unexpected event at cycle %0d, expected none", name, c);
  endtask
  always @(negedge clk) begin : mon_a
    iss_t ei;
    out_t eo;
    int ed;
    if (!reset) begin
      if (a_if.en) begin
        if (qa_iss.size() == 0) miss("a_issue", cyc);
        else begin
          ei = qa_iss.pop_front();
          chk("a_issue_cycle", cyc, ei.cyc);
          chk("a_ctrl", int'(a_if.ctrl), ei.ctrl);
          chk("a_w_addr", int'(a_if.w_addr), ei.w);
          chk("a_x_addr", int'(a_if.x_addr), ei.x);
        end
      end
      if (a_if.out_valid) begin
        if (qa_out.size() == 0) miss("a_out_valid", cyc);
        else begin
          eo = qa_out.pop_front();
          chk("a_out_cycle", cyc, eo.cyc);
          chk("a_out_row", int'(a_if.out_row), eo.row);
        end
      end
      if (a_if.done) begin
        if (qa_done.size() == 0) miss("a_done", cyc);
        else begin
          ed = qa_done.pop_front();
          chk("a_done_cycle", cyc, ed);
        end
      end
    end
  end
  always @(negedge clk) begin : mon_b
    iss_t ei;
    out_t eo;
    int ed;
    if (!reset) begin
      if (b_if.en) begin
        if (qb_iss.size() == 0) miss("b_issue", cyc);
        else begin
          ei = qb_iss.pop_front();
          chk("b_issue_cycle", cyc, ei.cyc);
          chk("b_ctrl", int'(b_if.ctrl), ei.ctrl);
          chk("b_w_addr", int'(b_if.w_addr), ei.w);
          chk("b_x_addr", int'(b_if.x_addr), ei.x);
        end
      end
      if (b_if.out_valid) begin
        if (qb_out.size() == 0) miss("b_out_valid", cyc);
        else begin
          eo = qb_out.pop_front();
          chk("b_out_cycle", cyc, eo.cyc);
          chk("b_out_row", int'(b_if.out_row), eo.row);
        end
      end
      if (b_if.done) begin
        if (qb_done.size() == 0) miss("b_done", cyc);
        else begin
          ed = qb_done.pop_front();
          chk("b_done_cycle", cyc, ed);
        end
      end
    end
  end
  // Issue k (0..5) lands at c0+1+k, pushed back by sl cycles from issue sa on; rows end on issues 2 and 5.
  task automatic expect_a(input int c0, input int sa, input int sl, input bit full);
    for (int k = 0; k < 6; k++) begin
      iss_t e;
      out_t o;
      e.cyc = c0 + 1 + k + (k >= sa ? sl : 0);
      e.ctrl = (k % 3 == 0) ? 1 : 0;
      e.w = k;
      e.x = k % 3;
      qa_iss.push_back(e);
      if (k % 3 == 2 && (k < 5 || full)) begin
        o.cyc = e.cyc + 2;
        o.row = k / 3;
        qa_out.push_back(o);
      end
    end
    if (full) qa_done.push_back(c0 + 9 + sl);
  endtask
  task automatic run_a(input int sa, input int sl, input bit restart, input bit rst_mid,
                       input int exp_cycles, input int exp_stalls);
    int c0;
    @(posedge clk);
    #1;
    a_if.mem_ready = 1'b1;
    a_if.start = 1'b1;
    c0 = cyc;
    expect_a(c0, sa, sl, !rst_mid);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      a_if.start = restart && k == 3;
      a_if.mem_ready = !(k > sa && k <= sa + sl);
      reset = rst_mid && k == 7;
      if (k > sa && k <= sa + sl) begin
        @(negedge clk);
        chk("a_stall_en", int'(a_if.en), 0);
        chk("a_stall_w_addr", int'(a_if.w_addr), 2);
      end
      if (rst_mid && k == 8) begin
        @(negedge clk);
        chk("a_post_reset_busy", int'(a_if.busy), 0);
        chk("a_post_reset_out_valid", int'(a_if.out_valid), 0);
        chk("a_post_reset_done", int'(a_if.done), 0);
      end
    end
    chk("a_leftover_expected", qa_iss.size() + qa_out.size() + qa_done.size(), 0);
    qa_iss.delete();
    qa_out.delete();
    qa_done.delete();
`ifdef MVM_SEQ_PERF_EN
    chk("a_perf_cycles", int'(a_if.perf_cycles), exp_cycles);
    chk("a_perf_stalls", int'(a_if.perf_stalls), exp_stalls);
`endif
  endtask
  task automatic run_b();
    int c0;
    iss_t e;
    out_t o;
    @(posedge clk);
    #1;
    b_if.start = 1'b1;
    c0 = cyc;
    e.cyc = c0 + 1;
    e.ctrl = 1;
    e.w = 0;
    e.x = 0;
    qb_iss.push_back(e);
    o.cyc = c0 + 2;
    o.row = 0;
    qb_out.push_back(o);
    qb_done.push_back(c0 + 3);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      b_if.start = 1'b0;
    end
    chk("b_leftover_expected", qb_iss.size() + qb_out.size() + qb_done.size(), 0);
`ifdef MVM_SEQ_PERF_EN
    chk("b_perf_cycles", int'(b_if.perf_cycles), 4);
    chk("b_perf_stalls", int'(b_if.perf_stalls), 0);
`endif
  endtask
  initial begin
    a_if.start = 1'b0;
    a_if.mem_ready = 1'b1;
    b_if.start = 1'b0;
    b_if.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(a_if.busy), 0);
    chk("rst_done", int'(a_if.done), 0);
    chk("rst_en", int'(a_if.en), 0);
    chk("rst_ctrl", int'(a_if.ctrl), 0);
    chk("rst_out_valid", int'(a_if.out_valid), 0);
    chk("rst_w_addr", int'(a_if.w_addr), 0);
    chk("rst_x_addr", int'(a_if.x_addr), 0);
    chk("rst_out_row", int'(a_if.out_row), 0);
    chk("rst_b_busy", int'(b_if.busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_a(6, 0, 1'b0, 1'b0, 10, 0);
    run_a(2, 3, 1'b0, 1'b0, 13, 3);
    run_a(6, 0, 1'b1, 1'b0, 10, 0);
    run_a(6, 0, 1'b0, 1'b1, 0, 0);
    run_a(6, 0, 1'b0, 1'b0, 10, 0);
    run_b();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mvm_tile_sequencer.md
MVM_TILE_SEQUENCER -- requirements
Module: mvm_tile_sequencer

Interface
REQ-001 SHALL have parameter EP, default 3: vector elements per column tile, matching the columnwise MVM EP.
REQ-002 SHALL have parameter VP, default 3: matrix rows per row tile, matching the columnwise MVM VP.
REQ-003 SHALL have parameter N_ROW_TILES, default 4: row tiles per matrix, >=1.
REQ-004 SHALL have parameter N_COL_TILES, default 4: column tiles per row tile, >=1.
REQ-005 SHALL have parameter KLAT, default 2: kernel cycles from operand issue to valid output, >=1.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port start, input, 1: pulse that begins one full matrix-vector product.
REQ-009 SHALL have port mem_ready, input, 1: operand source can supply the addressed tile this cycle.
REQ-010 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when the product is complete.
REQ-012 SHALL have port en, output, 1: an operand tile is issued to the MVM this cycle.
REQ-013 SHALL have port ctrl, output, 1: drives the MVM ctrl; 1 loads a new accumulation, 0 accumulates.
REQ-014 SHALL have port w_addr, output, clog2(N_ROW_TILES*N_COL_TILES): weight tile address.
REQ-015 SHALL have port x_addr, output, clog2(N_COL_TILES): vector tile address.
REQ-016 SHALL have port out_valid, output, 1: MVM out holds a finished row tile this cycle.
REQ-017 SHALL have port out_row, output, clog2(N_ROW_TILES): index of the row tile flagged by out_valid.
REQ-018 SHALL size every clog2 width as max(1, clog2(N)).

Function
REQ-019 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL move from IDLE to ISSUE on start, clearing row_cnt and col_cnt to 0.
REQ-021 SHALL, in ISSUE with mem_ready=1, assert en and advance col_cnt; on col_cnt wrap it SHALL reset col_cnt to 0 and increment row_cnt.
REQ-022 SHALL, in ISSUE with mem_ready=0, hold en=0 and all counters and addresses unchanged (stall).
REQ-023 SHALL drive w_addr = row_cnt*N_COL_TILES + col_cnt and x_addr = col_cnt combinationally from the counters.
REQ-024 SHALL assert ctrl=1 with en only when col_cnt=0, and ctrl=0 otherwise; with N_COL_TILES=1, ctrl=1 on every issue.
REQ-025 SHALL move from ISSUE to DRAIN on the issue of the last tile (row N_ROW_TILES-1, col N_COL_TILES-1).
REQ-026 SHALL assert out_valid, with out_row = that row tile, exactly KLAT cycles after the issue of each row tile's last column tile, using a KLAT-deep valid/index delay line.
REQ-027 SHALL leave DRAIN for DONE in the cycle the final out_valid is asserted, assert done for one cycle in DONE, then return to IDLE.
REQ-028 SHALL ignore start in ISSUE, DRAIN and DONE.
REQ-029 SHALL keep stalls from inserting or removing out_valid pulses: each row tile yields exactly one pulse.

Reset
REQ-030 SHALL, on reset, enter IDLE, clear the counters and the delay line, and drive busy, done, en, ctrl and out_valid to 0, with w_addr, x_addr and out_row at 0.
REQ-031 SHALL, on reset mid-operation, cancel all pending out_valid pulses and produce no done.

Configuration
REQ-032 SHALL, with MVM_SEQ_PERF_EN defined, add the 32-bit outputs perf_cycles (cycles from start to done inclusive) and perf_stalls (ISSUE cycles with mem_ready=0); both SHALL clear on start and on reset and hold after done.
REQ-033 SHALL, without MVM_SEQ_PERF_EN, omit those ports and their logic entirely.

Verification
REQ-034 SHALL cover: N_ROW_TILES=2, N_COL_TILES=3, KLAT=2, mem_ready=1 -> en high for 6 cycles; ctrl=1 on issues 1 and 4; w_addr 0..5; x_addr 0,1,2,0,1,2; out_valid with out_row 0 two cycles after issue 3 and out_row 1 two cycles after issue 6; done the cycle after.
REQ-035 SHALL cover: same configuration with mem_ready low for 3 cycles after issue 2 -> addresses hold at w_addr=2; out_valid pulses still 2; perf_stalls=3 when MVM_SEQ_PERF_EN is defined.
REQ-036 SHALL cover: start pulsed again during ISSUE -> no restart, and the issue sequence is unchanged.
REQ-037 SHALL cover: reset asserted during DRAIN -> next cycle IDLE, busy=0, and no further out_valid or done.
REQ-038 SHALL cover: N_ROW_TILES=1, N_COL_TILES=1, KLAT=1 -> one issue with ctrl=1, out_valid the next cycle, then the done pulse, and perf_cycles=4 when MVM_SEQ_PERF_EN is defined.
